// File: rtl/sim_halt_pkg.sv
// Shared types and constants for the simulation-termination controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sim_halt_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    function automatic logic is_ebreak(input logic [31:0] inst);
        return inst == EBREAK_INST;
    endfunction

endpackage

// File: rtl/sim_watchdog.sv
// No-commit watchdog: counts enabled, uncleared cycles and flags expiry.
// Latency: expired_o asserts combinationally in the WDOG_CYCLES-th idle cycle.
// Backpressure: none; the counter holds (never wraps) once it reaches its last value.
module sim_watchdog #(
    parameter int unsigned WDOG_CYCLES = 1048576
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(WDOG_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last   = (cnt_q == LAST);
    // A clear always takes priority, so a commit in the expiry cycle never times out.
    assign expired_o = enable_i && !clear_i && at_last;

    // Next count: clear to zero, otherwise advance while enabled and not yet at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !at_last) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sim_halt_ctrl.sv
// Ends simulation on ebreak commit or no-commit timeout, after the pipeline drains.
// Latency: fetch_stall one cycle after detection; halt one cycle after pipe_empty is seen in DRAIN.
// Backpressure: fetch_stall holds fetch from DRAIN onward; DRAIN lasts until pipe_empty.
module sim_halt_ctrl
    import sim_halt_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned WDOG_CYCLES = 1048576,
    parameter int unsigned CNT_W       = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit_valid,
    input  logic [31:0]      commit_inst,
    input  logic [XLEN-1:0]  commit_pc,
    input  logic             pipe_empty,
    input  logic [XLEN-1:0]  a0_value,
    output logic             fetch_stall,
    output logic             halt,
    output logic [1:0]       halt_cause,
    output logic [XLEN-1:0]  halt_pc,
    output logic [XLEN-1:0]  exit_code,
    output logic             good_trap,
    output logic [CNT_W-1:0] retired
);

    state_e            state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic [XLEN-1:0]   halt_pc_q, halt_pc_d;
    logic [XLEN-1:0]   exit_q, exit_d;
    logic              good_q, good_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [XLEN-1:0]   last_pc_q, last_pc_d;

    logic              wdog_clear;
    logic              wdog_en;
    logic              wdog_expired;

    // The watchdog only runs in RUN; DRAIN and HALTED freeze it.
    assign wdog_en    = (state_q == RUN);
    assign wdog_clear = (state_q == RUN) && commit_valid;

    sim_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (wdog_clear),
        .enable_i  (wdog_en),
        .expired_o (wdog_expired)
    );

    // Next-state and capture logic; an ebreak commit is checked before watchdog expiry.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        halt_pc_d = halt_pc_q;
        exit_d    = exit_q;
        good_d    = good_q;
        retired_d = retired_q;
        last_pc_d = last_pc_q;
        case (state_q)
            RUN: begin
                if (commit_valid) begin
                    retired_d = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
                    last_pc_d = commit_pc;
                    if (is_ebreak(commit_inst)) begin
                        halt_pc_d = commit_pc;
                        cause_d   = CAUSE_EBREAK;
                        state_d   = DRAIN;
                    end
                end else if (wdog_expired) begin
                    halt_pc_d = last_pc_q;
                    cause_d   = CAUSE_TIMEOUT;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    exit_d  = a0_value;
                    good_d  = (cause_q == CAUSE_EBREAK) && (a0_value == '0);
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            cause_q   <= CAUSE_NONE;
            halt_pc_q <= '0;
            exit_q    <= '0;
            good_q    <= 1'b0;
            retired_q <= '0;
            last_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            halt_pc_q <= halt_pc_d;
            exit_q    <= exit_d;
            good_q    <= good_d;
            retired_q <= retired_d;
            last_pc_q <= last_pc_d;
        end
    end

    // Outputs are pure decodes of registered state.
    assign fetch_stall = (state_q != RUN);
    assign halt        = (state_q == HALTED);
    assign halt_cause  = cause_q;
    assign halt_pc     = halt_pc_q;
    assign exit_code   = exit_q;
    assign good_trap   = good_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_sim_halt_ctrl.sv
module tb_sim_halt_ctrl;

    localparam int WD = 16;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clock;
    logic        reset;
    logic        commit_valid;
    logic [31:0] commit_inst;
    logic [63:0] commit_pc;
    logic        pipe_empty;
    logic [63:0] a0_value;
    logic        fetch_stall;
    logic        halt;
    logic [1:0]  halt_cause;
    logic [63:0] halt_pc;
    logic [63:0] exit_code;
    logic        good_trap;
    logic [63:0] retired;

    int vectors = 0;
    int fails   = 0;

    // Reference model: mode 0 running, 1 waiting for drain, 2 finished.
    int          m_mode;
    int          m_idle;
    logic [1:0]  m_cause;
    logic [63:0] m_halt_pc, m_exit, m_retired, m_last_pc;
    logic        m_good;

    sim_halt_ctrl #(
        .XLEN        (64),
        .WDOG_CYCLES (WD),
        .CNT_W       (64)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_inst  (commit_inst),
        .commit_pc    (commit_pc),
        .pipe_empty   (pipe_empty),
        .a0_value     (a0_value),
        .fetch_stall  (fetch_stall),
        .halt         (halt),
        .halt_cause   (halt_cause),
        .halt_pc      (halt_pc),
        .exit_code    (exit_code),
        .good_trap    (good_trap),
        .retired      (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [196:0] dut_vec();
        return {fetch_stall, halt, halt_cause, halt_pc, exit_code, good_trap, retired};
    endfunction

    function automatic logic [196:0] model_vec();
        logic s, h;
        s = (m_mode != 0);
        h = (m_mode == 2);
        return {s, h, m_cause, m_halt_pc, m_exit, m_good, m_retired};
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] v;
        v = $urandom;
        if (v == EBRK) v = v ^ 32'h1;
        return v;
    endfunction

    task automatic model_update();
        if (reset) begin
            m_mode = 0; m_idle = 0; m_cause = 2'd0; m_good = 1'b0;
            m_halt_pc = '0; m_exit = '0; m_retired = '0; m_last_pc = '0;
        end else if (m_mode == 0) begin
            if (commit_valid) begin
                if (m_retired != '1) m_retired = m_retired + 64'd1;
                m_last_pc = commit_pc;
                m_idle = 0;
                if (commit_inst == EBRK) begin
                    m_cause = 2'd1; m_halt_pc = commit_pc; m_mode = 1;
                end
            end else begin
                m_idle++;
                if (m_idle >= WD) begin
                    m_cause = 2'd2; m_halt_pc = m_last_pc; m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (pipe_empty) begin
                m_exit = a0_value;
                m_good = (m_cause == 2'd1) && (a0_value == 64'd0);
                m_mode = 2;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                         input logic pe, input logic [63:0] a0);
        commit_valid = v; commit_inst = inst; commit_pc = pc; pipe_empty = pe; a0_value = a0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 1'b0, 64'h0);
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, EBRK, 64'h8000_0040, 1'b1, 64'h0);
        tick(); tick();
        vectors++;
        if (dut_vec() !== 197'd0) begin
            fails++; $display("FAIL reset_vals: got %h want 0", dut_vec());
        end
        reset = 1'b0;
    endtask

    task automatic test_ebreak_basic();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, rnd_inst(), 64'h8000_0000 + 64'(4 * i), 1'b1, 64'($urandom));
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                fails++; $display("FAIL basic_commit%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        drive(1'b1, EBRK, 64'h8000_0014, 1'b1, 64'h0);
        tick();
        vectors++;
        if ({fetch_stall, halt} !== 2'b10) begin
            fails++; $display("FAIL basic_stall_n1: got %b want 10", {fetch_stall, halt});
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 64'h0);
        tick();
        vectors++;
        if ({halt, halt_cause, halt_pc, retired, good_trap} !== {1'b1, 2'd1, 64'h8000_0014, 64'd6, 1'b1}) begin
            fails++; $display("FAIL basic_halt_n2: got h=%b c=%0d pc=%h r=%0d g=%b want h=1 c=1 pc=80000014 r=6 g=1",
                              halt, halt_cause, halt_pc, retired, good_trap);
        end
        vectors++;
        if (dut_vec() !== model_vec()) begin
            fails++; $display("FAIL basic_model: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_drain_exit_code();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, rnd_inst(), 64'h8000_0200 + 64'(4 * i), 1'b0, 64'd5);
            tick();
        end
        drive(1'b1, EBRK, 64'h8000_0208, 1'b0, 64'd5);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(k < 2, (k == 0) ? EBRK : rnd_inst(), 64'h8000_0300, 1'b0, 64'd5);
            tick();
            vectors++;
            if ({fetch_stall, halt, retired} !== {1'b1, 1'b0, 64'd3}) begin
                fails++; $display("FAIL drain_wait%0d: got s=%b h=%b r=%0d want s=1 h=0 r=3", k, fetch_stall, halt, retired);
            end
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 64'd7);
        tick();
        vectors++;
        if ({halt, exit_code, good_trap, retired, halt_pc} !== {1'b1, 64'd7, 1'b0, 64'd3, 64'h8000_0208}) begin
            fails++; $display("FAIL drain_exit: got h=%b x=%0d g=%b r=%0d pc=%h want h=1 x=7 g=0 r=3 pc=80000208",
                              halt, exit_code, good_trap, retired, halt_pc);
        end
        vectors++;
        if (dut_vec() !== model_vec()) begin
            fails++; $display("FAIL drain_model: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(1'b1, rnd_inst(), 64'h8000_0100, 1'b0, 64'd0);
        tick();
        for (int k = 1; k <= WD; k++) begin
            drive(1'b0, 32'h0, 64'h0, 1'b0, 64'd0);
            tick();
            vectors++;
            if (fetch_stall !== (k == WD)) begin
                fails++; $display("FAIL timeout_idle%0d: got stall=%b want %b", k, fetch_stall, (k == WD));
            end
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 64'd0);
        tick();
        vectors++;
        if ({halt, halt_cause, halt_pc, good_trap} !== {1'b1, 2'd2, 64'h8000_0100, 1'b0}) begin
            fails++; $display("FAIL timeout_halt: got h=%b c=%0d pc=%h g=%b want h=1 c=2 pc=80000100 g=0",
                              halt, halt_cause, halt_pc, good_trap);
        end
    endtask

    task automatic test_ebreak_at_expiry();
        do_reset();
        drive(1'b1, rnd_inst(), 64'h8000_0500, 1'b0, 64'd0);
        tick();
        for (int k = 1; k < WD; k++) begin
            drive(1'b0, 32'h0, 64'h0, 1'b0, 64'd0);
            tick();
        end
        drive(1'b1, EBRK, 64'h8000_0504, 1'b0, 64'd0);
        tick();
        vectors++;
        if ({fetch_stall, halt_cause} !== {1'b1, 2'd1}) begin
            fails++; $display("FAIL expiry_cause: got s=%b c=%0d want s=1 c=1", fetch_stall, halt_cause);
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 64'd0);
        tick();
        vectors++;
        if ({halt, halt_cause, halt_pc, retired} !== {1'b1, 2'd1, 64'h8000_0504, 64'd2}) begin
            fails++; $display("FAIL expiry_halt: got h=%b c=%0d pc=%h r=%0d want h=1 c=1 pc=80000504 r=2",
                              halt, halt_cause, halt_pc, retired);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, rnd_inst(), 64'h8000_0600 + 64'(4 * i), 1'b0, 64'd9);
            tick();
        end
        drive(1'b1, EBRK, 64'h8000_0608, 1'b0, 64'd9);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (dut_vec() !== 197'd0) begin
            fails++; $display("FAIL middrain_reset: got %h want 0", dut_vec());
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd_inst(), 64'h8000_0700 + 64'(4 * i), 1'b1, 64'd0);
            tick();
        end
        drive(1'b1, EBRK, 64'h8000_070c, 1'b1, 64'd0);
        tick();
        drive(1'b0, 32'h0, 64'h0, 1'b1, 64'd0);
        tick();
        vectors++;
        if ({halt, halt_cause, halt_pc, retired, good_trap} !== {1'b1, 2'd1, 64'h8000_070c, 64'd4, 1'b1}) begin
            fails++; $display("FAIL middrain_rerun: got h=%b c=%0d pc=%h r=%0d g=%b want h=1 c=1 pc=8000070c r=4 g=1",
                              halt, halt_cause, halt_pc, retired, good_trap);
        end
    endtask

    task automatic test_halted_frozen();
        logic [196:0] snap;
        snap = model_vec();
        for (int k = 0; k < 20; k++) begin
            drive(1'($urandom), EBRK, 64'($urandom), 1'($urandom), 64'($urandom));
            tick();
            vectors++;
            if (dut_vec() !== snap) begin
                fails++; $display("FAIL frozen%0d: got %h want %h", k, dut_vec(), snap);
            end
        end
    endtask

    task automatic test_random();
        int rate;
        logic v;
        do_reset();
        rate = 50;
        for (int k = 0; k < 3000; k++) begin
            if (k % 150 == 0) rate = $urandom_range(0, 3) * 25 + 2;
            v = ($urandom_range(0, 99) < rate);
            reset = (m_mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            drive(v, ($urandom_range(0, 19) == 0) ? EBRK : rnd_inst(), 64'($urandom) << 2,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0) ? 64'd0 : 64'($urandom));
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                fails++; $display("FAIL random%0d: got %h want %h", k, dut_vec(), model_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m_mode = 0; m_idle = 0; m_cause = 2'd0; m_good = 1'b0;
        m_halt_pc = '0; m_exit = '0; m_retired = '0; m_last_pc = '0;
        drive(1'b0, 32'h0, 64'h0, 1'b0, 64'h0);
        test_reset();
        test_ebreak_basic();
        test_halted_frozen();
        test_drain_exit_code();
        test_timeout();
        test_ebreak_at_expiry();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
